crc_frame_serializer: RTL and testbench

- Downstream neighbour of the CRC framing stage.
- Reads the 16-bit framed words {flag[1:0], payload[9:0], crc[3:0]} from the shared frame RAM, starting at BASE_ADDR.
- Shifts each word out MSB-first on a serial data line, with a generated serial clock and output-enable strobes.
- Checks the flag sequence (01 = first, 10 = middle, 11 = last) and stops after the last word or after MAX_WORDS.

---
 rtl/crc_frame_serializer.sv | 228 ++++++++++++++++++++++
 tb/tb_crc_frame_serializer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_serializer.sv
// crc_frame_serializer
//   Reads framed words {flag[1:0], payload, crc[3:0]} from the shared frame RAM
//   starting at BASE_ADDR and shifts each one out MSB-first with a generated
//   serial clock. The flag sequence is checked: 01 first, then 10 (middle) or
//   11 (last). The transfer stops after the last word or after MAX_WORDS words.
//
// Optional feature macro: CRC_CHECK_EN (adds crc_err and a CRC-4 check per word).
//
// Ports:
//   clk, rst     system clock (rising edge), asynchronous active-high reset
//   start        one-cycle pulse; accepted only while idle
//   rd_addr      registered RAM read address
//   rd_q         RAM read data, valid one cycle after rd_addr changes
//   ser_data     serial data, MSB first
//   ser_clk      serial clock; data is stable at its rising edge
//   data_oe      ser_data output enable
//   clk_oe       ser_clk output enable
//   busy         transfer in progress
//   done         one-cycle end-of-transfer pulse
//   frame_err    flag-sequence violation, sticky until the next accepted start
//   crc_err      (CRC_CHECK_EN only) CRC mismatch, sticky until the next start
//   word_cnt     words fully shifted in the current or last transfer
module crc_frame_serializer #(
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 14,
  parameter int unsigned CLK_DIV   = 4,
  parameter logic [4:0]  POLY      = 5'b10011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] rd_q,
  output logic              ser_data,
  output logic              ser_clk,
  output logic              data_oe,
  output logic              clk_oe,
  output logic              busy,
  output logic              done,
  output logic              frame_err,
`ifdef CRC_CHECK_EN
  output logic              crc_err,
`endif
  output logic [ADDR_W-1:0] word_cnt
);

  localparam int unsigned BIT_W = $clog2(WORD_W);
  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PAY_W = WORD_W - 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [1:0]          flag_q, flag_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
  logic                frame_err_q, frame_err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ser_data_q, ser_data_d;
  logic                ser_clk_q, ser_clk_d;
  logic                oe_q, oe_d;

  // Flag of the word currently presented by the RAM and whether it fits the sequence
  logic [1:0] rd_flag_c;
  logic       flag_ok_c;
  assign rd_flag_c = rd_q[WORD_W-1 -: 2];
  assign flag_ok_c = (word_cnt_q == '0) ? (rd_flag_c == 2'b01) : rd_flag_c[1];

`ifdef CRC_CHECK_EN
  logic crc_err_q, crc_err_d;
  logic crc_bad_c;

  // Remainder of {payload, 4'b0000} modulo POLY by long division
  function automatic logic [3:0] crc_rem(input logic [PAY_W-1:0] pay);
    logic [PAY_W+3:0] r;
    r = {pay, 4'b0000};
    for (int i = PAY_W + 3; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ POLY;
    end
    return r[3:0];
  endfunction

  assign crc_bad_c = (crc_rem(rd_q[WORD_W-3:4]) != rd_q[3:0]);
  assign crc_err   = crc_err_q;
`else
  logic unused_poly;
  assign unused_poly = ^POLY;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= ADDR_W'(BASE_ADDR);
      shift_q     <= '0;
      flag_q      <= '0;
      bit_q       <= '0;
      div_q       <= '0;
      word_cnt_q  <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_clk_q   <= 1'b0;
      oe_q        <= 1'b0;
`ifdef CRC_CHECK_EN
      crc_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      shift_q     <= shift_d;
      flag_q      <= flag_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      word_cnt_q  <= word_cnt_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ser_data_q  <= ser_data_d;
      ser_clk_q   <= ser_clk_d;
      oe_q        <= oe_d;
`ifdef CRC_CHECK_EN
      crc_err_q   <= crc_err_d;
`endif
    end
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    shift_d     = shift_q;
    flag_d      = flag_q;
    bit_d       = bit_q;
    div_d       = div_q;
    word_cnt_d  = word_cnt_q;
    frame_err_d = frame_err_q;
`ifdef CRC_CHECK_EN
    crc_err_d   = crc_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_FETCH;
          rd_addr_d   = ADDR_W'(BASE_ADDR);
          word_cnt_d  = '0;
          frame_err_d = 1'b0;
`ifdef CRC_CHECK_EN
          crc_err_d   = 1'b0;
`endif
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shift_d = rd_q;
        flag_d  = rd_flag_c;
        bit_d   = '0;
        div_d   = '0;
`ifdef CRC_CHECK_EN
        if (crc_bad_c) crc_err_d = 1'b1;
`endif
        if (flag_ok_c) begin
          state_d = S_SHIFT;
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d   = '0;
          shift_d = {shift_q[WORD_W-2:0], 1'b0};
          if (bit_q == BIT_W'(WORD_W - 1)) begin
            state_d = S_NEXT;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_NEXT: begin
        word_cnt_d = word_cnt_q + ADDR_W'(1);
        if (flag_q == 2'b11 || (word_cnt_q + ADDR_W'(1)) == ADDR_W'(MAX_WORDS)) begin
          state_d = S_DONE;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          state_d   = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Serial outputs are the registered image of the current shift state
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_q == S_DONE);
    oe_d       = (state_q == S_SHIFT);
    ser_data_d = (state_q == S_SHIFT) && shift_q[WORD_W-1];
    ser_clk_d  = (state_q == S_SHIFT) && (div_q >= DIV_W'(CLK_DIV / 2));
  end

  assign rd_addr   = rd_addr_q;
  assign ser_data  = ser_data_q;
  assign ser_clk   = ser_clk_q;
  assign data_oe   = oe_q;
  assign clk_oe    = oe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_err = frame_err_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Directed bench for crc_frame_serializer with a word-level reference model.
module tb_crc_frame_serializer;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned BASE   = 0;
  localparam int unsigned MAXW   = 14;
  localparam int unsigned DIV    = 4;
  localparam int          WP     = 16 * DIV + 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_q;
  logic              ser_data, ser_clk, data_oe, clk_oe, busy, done, frame_err;
  logic [ADDR_W-1:0] word_cnt;
`ifdef CRC_CHECK_EN
  logic              crc_err;
`endif

  logic [WORD_W-1:0] ram [32];

  int errors = 0;
  int checks = 0;

  // Reference model results
  int m_nw;
  int m_done_n;
  int m_fetched;
  bit m_abort;
  bit m_crc;

  always #5 clk = ~clk;

  always @(posedge clk) rd_q <= ram[rd_addr];

  crc_frame_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_q      (rd_q),
    .ser_data  (ser_data),
    .ser_clk   (ser_clk),
    .data_oe   (data_oe),
    .clk_oe    (clk_oe),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err),
`ifdef CRC_CHECK_EN
    .crc_err   (crc_err),
`endif
    .word_cnt  (word_cnt)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // CRC-4 (x^4+x+1) remainder of payload*x^4 by polynomial long division
  function automatic int crc_ref(input int pay);
    int r;
    r = pay << 4;
    for (int i = 13; i >= 4; i--) begin
      if (((r >> i) & 1) == 1) r = r ^ (32'h13 << (i - 4));
    end
    return r & 32'hF;
  endfunction

  function automatic logic [WORD_W-1:0] word_at(input int w);
    return ram[(BASE + w) % 32];
  endfunction

  // Walks the RAM with the framing rules and derives word count and timing
  task automatic model();
    m_nw = 0; m_abort = 0; m_crc = 0;
    for (int w = 0; w < int'(MAXW); w++) begin
      logic [WORD_W-1:0] wd;
      int f;
      bit ok;
      wd = word_at(w);
      f  = int'(wd[15:14]);
      if (crc_ref(int'(wd[13:4])) != int'(wd[3:0])) m_crc = 1;
      ok = (w == 0) ? (f == 1) : (f >= 2);
      if (!ok) begin
        m_abort = 1;
        break;
      end
      m_nw++;
      if (f == 3) break;
    end
    m_done_n  = m_abort ? (3 + WP * m_nw) : (WP * m_nw + 1);
    m_fetched = m_abort ? (m_nw + 1) : m_nw;
  endtask

  // One transfer; restart_n / rst_at select a stray start or a reset at sample n (-1 = none)
  task automatic run_xfer(input string name, input int restart_n, input int rst_at);
    logic [63:0] bits, exp_bits;
    int          nbits;
    logic        prev_clk;
    bits = '0; exp_bits = '0; nbits = 0; prev_clk = 1'b0;
    model();
    for (int w = 0; w < m_nw; w++) exp_bits = {exp_bits[47:0], word_at(w)};

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n <= m_done_n + 2; n++) begin
      int  w, r;
      bit  in_sh, e_clk, e_dat;
      logic [WORD_W-1:0] wd;
      w = (n - 3) / WP; r = (n - 3) % WP;
      in_sh = (n >= 3) && (w < m_nw) && (r < 16 * DIV);
      wd    = in_sh ? word_at(w) : '0;
      e_clk = in_sh && ((r % DIV) >= DIV / 2);
      e_dat = in_sh && wd[15 - r / DIV];
      chk($sformatf("%s data_oe n=%0d", name, n), data_oe, in_sh);
      chk($sformatf("%s clk_oe n=%0d", name, n), clk_oe, in_sh);
      chk($sformatf("%s ser_clk n=%0d", name, n), ser_clk, e_clk);
      chk($sformatf("%s ser_data n=%0d", name, n), ser_data, e_dat);
      chk($sformatf("%s busy n=%0d", name, n), busy, n < m_done_n);
      chk($sformatf("%s done n=%0d", name, n), done, n == m_done_n);
      if (ser_clk && !prev_clk) begin
        bits = {bits[62:0], ser_data};
        nbits++;
      end
      prev_clk = ser_clk;
      if (n == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk({name, " rst outs"}, {ser_data, ser_clk, data_oe, clk_oe, busy, done, frame_err}, 0);
        chk({name, " rst word_cnt"}, word_cnt, 0);
        chk({name, " rst rd_addr"}, rd_addr, BASE);
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk($sformatf("%s post-rst done k=%0d", name, k), done, 0);
          chk($sformatf("%s post-rst busy k=%0d", name, k), busy, 0);
        end
        return;
      end
      start = (n == restart_n);
      @(negedge clk);
    end
    start = 1'b0;
    chk({name, " word_cnt"}, word_cnt, m_nw);
    chk({name, " frame_err"}, frame_err, m_abort);
    chk({name, " rd_addr"}, rd_addr, (BASE + m_fetched - 1) % 32);
    chk({name, " nbits"}, nbits, 16 * m_nw);
    chk({name, " bits"}, bits, exp_bits);
`ifdef CRC_CHECK_EN
    chk({name, " crc_err"}, crc_err, m_crc);
`endif
  endtask

  task automatic load_basic();
    for (int i = 0; i < 32; i++) ram[i] = 16'h8000;
    ram[0] = 16'h4005; ram[1] = 16'h8AAA; ram[2] = 16'hC3C3;
  endtask

  initial begin
    start = 1'b0;
    rst   = 1'b1;
    for (int i = 0; i < 32; i++) ram[i] = '0;
    #1;
    chk("reset outs", {ser_data, ser_clk, data_oe, clk_oe, busy, done, frame_err}, 0);
    chk("reset word_cnt", word_cnt, 0);
    chk("reset rd_addr", rd_addr, BASE);
    #20 rst = 1'b0;

    // Hand-computed pins for the reference model
    chk("pin crc(001)", crc_ref(1), 3);
    chk("pin crc(000)", crc_ref(0), 0);

    load_basic();
    model();
    chk("pin basic nw", m_nw, 3);
    chk("pin basic done_n", m_done_n, 202);
    run_xfer("basic", -1, -1);
    chk("basic literal stream", {16'h0, 16'h4005, 16'h8AAA, 16'hC3C3},
        {16'h0, word_at(0), word_at(1), word_at(2)});

    ram[0] = 16'h8AAA;
    model();
    chk("pin badfirst done_n", m_done_n, 3);
    run_xfer("badfirst", -1, -1);

    for (int i = 0; i < 32; i++) ram[i] = 16'h8AAA;
    ram[0] = 16'h4005;
    model();
    chk("pin limit done_n", m_done_n, 939);
    chk("pin limit rd_addr", m_fetched - 1, 13);
    run_xfer("limit", -1, -1);

    load_basic();
    ram[1] = 16'h0123;
    model();
    chk("pin flag00 done_n", m_done_n, 70);
    run_xfer("flag00", -1, -1);

    load_basic();
    run_xfer("rst_mid", -1, 3 + 2 * WP + 7 * DIV + 1);
    run_xfer("after_rst", -1, -1);
    run_xfer("restart_mid", 100, -1);
    run_xfer("start_in_done", 201, -1);

`ifdef CRC_CHECK_EN
    for (int i = 0; i < 32; i++) ram[i] = 16'h8000;
    ram[0] = 16'h4013; ram[1] = 16'hC000;
    model();
    chk("pin crc good", m_crc, 0);
    run_xfer("crc_good", -1, -1);
    ram[0] = 16'h4014;
    model();
    chk("pin crc bad", m_crc, 1);
    run_xfer("crc_bad", -1, -1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
